// File: rtl/stage_sequencer.sv
// Sequences NUM_STAGES solver stages one at a time, with a per-stage timeout and a shared-resource owner select.
// Latency: a sampled run rise gives stage_start[0] one cycle later; stage_end[i] gives the next start (or done) one cycle later.
// No backpressure: a stage holds ownership until its end handshake, a timeout, or an abort.
module stage_sequencer #(
    parameter int NUM_STAGES     = 8,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  program_reset,
    input  logic                  run,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_end,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [SEL_W-1:0]      owner_sel,
    output logic                  owner_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [SEL_W-1:0]      error_stage,
    output logic [2:0]            cs
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX     = SEL_W'(NUM_STAGES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] idx;
    logic [15:0]      timer;
    logic             run_q;
    logic             rise;
    logic             cur_end;
    logic             timeout_hit;

    // Only the end bit of the stage currently owned matters; all others are ignored.
    assign rise        = run & ~run_q;
    assign cur_end     = stage_end[idx];
    assign timeout_hit = (timer == TIMEOUT_LAST);
    assign cs          = state;

    // State register; reset drops straight back to IDLE so a sequence never resumes.
    always_ff @(posedge clk or negedge program_reset) begin
        if (!program_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs; abort outranks every WAIT exit and end outranks timeout.
    always_comb begin
        state_nxt   = state;
        stage_start = '0;
        owner_sel   = '0;
        owner_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                stage_start = NUM_STAGES'(1) << idx;
                owner_sel   = idx;
                owner_valid = 1'b1;
                busy        = 1'b1;
                state_nxt   = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                owner_sel   = idx;
                owner_valid = 1'b1;
                busy        = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (cur_end) begin
                    state_nxt = (idx == LAST_IDX) ? S_FINISH : S_LAUNCH;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (rise) state_nxt = S_LAUNCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage index, WAIT timer, run edge history and the sticky timeout record.
    always_ff @(posedge clk or negedge program_reset) begin
        if (!program_reset) begin
            idx         <= '0;
            timer       <= '0;
            run_q       <= 1'b0;
            error       <= 1'b0;
            error_stage <= '0;
        end else begin
            run_q <= run;
            case (state)
                S_IDLE, S_FAULT: begin
                    if (rise) begin
                        idx         <= '0;
                        error       <= 1'b0;
                        error_stage <= '0;
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    if (timer != 16'hFFFF) timer <= timer + 16'd1;
                    if (!abort) begin
                        if (cur_end) begin
                            if (idx != LAST_IDX) idx <= idx + 1'b1;
                        end else if (timeout_hit) begin
                            error       <= 1'b1;
                            error_stage <= idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: expected start/done events are queued with their cycle numbers.
// A monitor pops and compares on every cycle that shows a stage_start or done.
// State and flag checks at chosen cycles are made alongside in the stimulus.
module tb_stage_sequencer;
    localparam int NS = 8;
    localparam int SW = 3;
    localparam int TO = 10;

    logic          clk           = 1'b0;
    logic          program_reset = 1'b1;
    logic          run           = 1'b0;
    logic          abort         = 1'b0;
    logic [NS-1:0] stage_end     = '0;
    logic [NS-1:0] stage_start;
    logic [SW-1:0] owner_sel;
    logic          owner_valid;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] error_stage;
    logic [2:0]    cs;

    stage_sequencer #(
        .NUM_STAGES    (NS),
        .SEL_W         (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .program_reset(program_reset),
        .run          (run),
        .abort        (abort),
        .stage_end    (stage_end),
        .stage_start  (stage_start),
        .owner_sel    (owner_sel),
        .owner_valid  (owner_valid),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_stage  (error_stage),
        .cs           (cs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [NS-1:0] start;
        logic          done;
        logic [SW-1:0] sel;
    } ev_t;

    ev_t exp_q[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  stop      = 1'b0;

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step1();
    endtask

    task automatic expect_ev(input int c, input int st, input bit d, input int sel);
        ev_t e;
        e.cyc   = c;
        e.start = NS'(st);
        e.done  = d;
        e.sel   = SW'(sel);
        exp_q.push_back(e);
    endtask

    task automatic pulse_end(input int t, input int i);
        goto(t);
        stage_end = NS'(1) << i;
        goto(t + 1);
        stage_end = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        #2 program_reset = 1'b0;
        fork
            begin : monitor
                ev_t e;
                while (!stop) begin
                    @(negedge clk);
                    if (stage_start != '0 || done) begin
                        total_cnt++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL unexpected_event: cyc=%0d start=%b done=%b sel=%0d, none expected",
                                     cyc, stage_start, done, owner_sel);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc == cyc && e.start == stage_start && e.done == done && e.sel == owner_sel)
                                pass_cnt++;
                            else
                                $display("FAIL event: got cyc=%0d start=%b done=%b sel=%0d, expected cyc=%0d start=%b done=%b sel=%0d",
                                         cyc, stage_start, done, owner_sel, e.cyc, e.start, e.done, e.sel);
                        end
                    end
                end
            end
            begin : stimulus
                int c0;
                // Reset state
                goto(3);
                chk("rst_cs", cs, 0);
                chk("rst_busy", busy, 0);
                chk("rst_owner_valid", owner_valid, 0);
                chk("rst_error", error, 0);
                program_reset = 1'b1;
                goto(cyc + 2);

                // Full eight-stage sequence, each end three cycles after its start
                c0 = cyc;
                for (int i = 0; i < NS; i++) expect_ev(c0 + 1 + 4 * i, 1 << i, 1'b0, i);
                expect_ev(c0 + 33, 0, 1'b1, 0);
                run = 1'b1;
                goto(c0 + 2);
                chk("s1_wait_cs", cs, 2);
                chk("s1_owner_valid", owner_valid, 1);
                chk("s1_busy", busy, 1);
                for (int i = 0; i < NS; i++) pulse_end(c0 + 4 + 4 * i, i);
                goto(c0 + 34);
                chk("s1_idle_cs", cs, 0);
                chk("s1_error", error, 0);
                chk("s1_busy_after", busy, 0);
                chk("s1_drained", exp_q.size(), 0);
                run = 1'b0;
                step1();

                // Stage 2 never ends: fault ten cycles after WAIT entry, then relaunch
                c0 = cyc;
                expect_ev(c0 + 1, 1, 1'b0, 0);
                expect_ev(c0 + 5, 2, 1'b0, 1);
                expect_ev(c0 + 9, 4, 1'b0, 2);
                run = 1'b1;
                pulse_end(c0 + 4, 0);
                pulse_end(c0 + 8, 1);
                goto(c0 + 19);
                chk("s2_last_wait_cs", cs, 2);
                chk("s2_no_error_yet", error, 0);
                goto(c0 + 20);
                chk("s2_fault_cs", cs, 4);
                chk("s2_error", error, 1);
                chk("s2_error_stage", error_stage, 2);
                chk("s2_fault_busy", busy, 0);
                chk("s2_fault_owner_valid", owner_valid, 0);
                pulse_end(c0 + 22, 2);
                goto(c0 + 26);
                chk("s2_fault_hold_cs", cs, 4);
                chk("s2_fault_hold_error", error, 1);
                run = 1'b0;
                goto(c0 + 27);
                run = 1'b1;
                expect_ev(c0 + 28, 1, 1'b0, 0);
                goto(c0 + 28);
                chk("s2_relaunch_cs", cs, 1);
                chk("s2_error_cleared", error, 0);
                chk("s2_error_stage_cleared", error_stage, 0);
                abort = 1'b1;
                goto(c0 + 29);
                abort = 1'b0;
                chk("s2_abort_launch_cs", cs, 0);
                chk("s2_drained", exp_q.size(), 0);
                run = 1'b0;
                step1();

                // End arriving on the exact timeout cycle wins
                c0 = cyc;
                expect_ev(c0 + 1, 1, 1'b0, 0);
                expect_ev(c0 + 12, 2, 1'b0, 1);
                run = 1'b1;
                pulse_end(c0 + 11, 0);
                goto(c0 + 12);
                chk("s3_advance_cs", cs, 1);
                chk("s3_no_error", error, 0);
                abort = 1'b1;
                goto(c0 + 13);
                abort = 1'b0;
                chk("s3_abort_cs", cs, 0);
                chk("s3_drained", exp_q.size(), 0);
                run = 1'b0;
                step1();

                // Spurious end bits are ignored
                c0 = cyc;
                expect_ev(c0 + 1, 1, 1'b0, 0);
                expect_ev(c0 + 5, 2, 1'b0, 1);
                expect_ev(c0 + 10, 4, 1'b0, 2);
                run = 1'b1;
                goto(c0 + 1);
                stage_end = 8'b0000_0001;
                goto(c0 + 2);
                stage_end = '0;
                chk("s4_launch_end_ignored_cs", cs, 2);
                chk("s4_launch_end_ignored_sel", owner_sel, 0);
                pulse_end(c0 + 4, 0);
                goto(c0 + 6);
                stage_end = 8'b0010_0000;
                goto(c0 + 9);
                stage_end = '0;
                chk("s4_other_end_ignored_cs", cs, 2);
                chk("s4_other_end_ignored_sel", owner_sel, 1);
                pulse_end(c0 + 9, 1);
                abort = 1'b1;
                goto(c0 + 11);
                abort = 1'b0;
                chk("s4_abort_cs", cs, 0);
                chk("s4_drained", exp_q.size(), 0);
                run = 1'b0;
                step1();

                // Abort in WAIT of stage 4; held run must not relaunch
                c0 = cyc;
                for (int i = 0; i < 5; i++) expect_ev(c0 + 1 + 4 * i, 1 << i, 1'b0, i);
                run = 1'b1;
                for (int i = 0; i < 4; i++) pulse_end(c0 + 4 + 4 * i, i);
                goto(c0 + 19);
                abort = 1'b1;
                goto(c0 + 20);
                abort = 1'b0;
                chk("s5_abort_cs", cs, 0);
                chk("s5_abort_owner_valid", owner_valid, 0);
                chk("s5_abort_owner_sel", owner_sel, 0);
                chk("s5_abort_busy", busy, 0);
                pulse_end(c0 + 21, 4);
                goto(c0 + 30);
                chk("s5_held_run_idle", cs, 0);
                run = 1'b0;
                goto(c0 + 31);
                run = 1'b1;
                expect_ev(c0 + 32, 1, 1'b0, 0);
                goto(c0 + 32);
                chk("s5_relaunch_cs", cs, 1);
                abort = 1'b1;
                goto(c0 + 33);
                abort = 1'b0;
                run = 1'b0;
                chk("s5_drained", exp_q.size(), 0);
                step1();

                // Asynchronous reset in WAIT of stage 3, no resume afterwards
                c0 = cyc;
                for (int i = 0; i < 4; i++) expect_ev(c0 + 1 + 4 * i, 1 << i, 1'b0, i);
                run = 1'b1;
                for (int i = 0; i < 3; i++) pulse_end(c0 + 4 + 4 * i, i);
                goto(c0 + 15);
                #2 program_reset = 1'b0;
                #1;
                chk("s6_async_cs", cs, 0);
                chk("s6_async_busy", busy, 0);
                chk("s6_async_owner_valid", owner_valid, 0);
                chk("s6_async_owner_sel", owner_sel, 0);
                chk("s6_async_start", stage_start, 0);
                run = 1'b0;
                goto(c0 + 17);
                program_reset = 1'b1;
                goto(c0 + 22);
                chk("s6_no_resume_cs", cs, 0);
                chk("s6_drained", exp_q.size(), 0);
                program_reset = 1'b0;
                run = 1'b1;
                goto(c0 + 24);
                expect_ev(c0 + 25, 1, 1'b0, 0);
                program_reset = 1'b1;
                goto(c0 + 25);
                chk("s6_held_run_launch_cs", cs, 1);
                abort = 1'b1;
                goto(c0 + 26);
                abort = 1'b0;
                run = 1'b0;
                chk("s6_abort_cs", cs, 0);

                goto(cyc + 3);
                chk("final_drained", exp_q.size(), 0);
                stop = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
